// File: rtl/shadowmask_if.sv
// Host config and video sync bundle for the shadow-mask controller.
// master = host/video source side, slave = controller side.
interface shadowmask_if;
  logic       cfg_wr;
  logic [5:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_commit;
  logic       cfg_busy;
  logic       hs_in;
  logic       vs_in;
  logic       de_in;
  logic [2:0] mask_rgb;
  logic       mask_en;
  logic       hs_out;
  logic       vs_out;
  logic       de_out;

  modport master (
    output cfg_wr, cfg_addr, cfg_data, cfg_commit,
    output hs_in, vs_in, de_in,
    input  cfg_busy, mask_rgb, mask_en,
    input  hs_out, vs_out, de_out
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, cfg_commit,
    input  hs_in, vs_in, de_in,
    output cfg_busy, mask_rgb, mask_en,
    output hs_out, vs_out, de_out
  );
endinterface

// File: rtl/shadowmask_ctrl.sv
// Double-buffered shadow-mask pattern store with vsync-aligned bank swap
// and horizontal/vertical phase counters driving a registered mask code.
module shadowmask_ctrl (
  input  logic clk,
  input  logic reset,
  shadowmask_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, COPY} state_e;

  state_e     state_q, state_d;
  logic       act_q, act_d;
  logic [2:0] lut_q [2][32];
  logic [2:0] lut_d [2][32];
  logic [3:0] width_q [2];
  logic [3:0] width_d [2];
  logic [2:0] height_q [2];
  logic [2:0] height_d [2];
  logic       en_q [2];
  logic       en_d [2];
  logic [4:0] idx_q, idx_d;
  logic [2:0] hcount_q, hcount_d;
  logic [1:0] vcount_q, vcount_d;
  logic       old_hs_q, old_vs_q;
  logic [2:0] mask_q, mask_d;
  logic       mask_en_q, mask_en_d;
  logic       hs_out_q, vs_out_q, de_out_q;

  logic       hs_fall, vs_fall;
  logic [3:0] wclamp;
  logic [2:0] hclamp;
  logic       unused_ok;

  assign hs_fall = old_hs_q & ~bus.hs_in;
  assign vs_fall = old_vs_q & ~bus.vs_in;
  assign unused_ok = &{1'b0, bus.cfg_data[7:4]};

  always_comb begin
    wclamp = bus.cfg_data[3:0];
    if (wclamp == 4'd0) wclamp = 4'd1;
    else if (wclamp > 4'd8) wclamp = 4'd8;
    hclamp = bus.cfg_data[2:0];
    if (hclamp == 3'd0) hclamp = 3'd1;
    else if (hclamp > 3'd4) hclamp = 3'd4;
  end

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    idx_d    = idx_q;
    lut_d    = lut_q;
    width_d  = width_q;
    height_d = height_q;
    en_d     = en_q;
    case (state_q)
      IDLE: begin
        if (bus.cfg_wr) begin
          if (!bus.cfg_addr[5])
            lut_d[~act_q][bus.cfg_addr[4:0]] = bus.cfg_data[2:0];
          else if (bus.cfg_addr == 6'd32)
            width_d[~act_q] = wclamp;
          else if (bus.cfg_addr == 6'd33)
            height_d[~act_q] = hclamp;
          else if (bus.cfg_addr == 6'd34)
            en_d[~act_q] = bus.cfg_data[0];
        end
        if (bus.cfg_commit) state_d = ARMED;
      end
      ARMED: begin
        if (vs_fall) begin
          act_d            = ~act_q;
          width_d[act_q]   = width_q[~act_q];
          height_d[act_q]  = height_q[~act_q];
          en_d[act_q]      = en_q[~act_q];
          idx_d            = 5'd0;
          state_d          = COPY;
        end
      end
      COPY: begin
        // act already points at the new bank; refresh the shadow copy
        lut_d[~act_q][idx_q] = lut_q[act_q][idx_q];
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (hs_fall)
      hcount_d = 3'd0;
    else if ({1'b0, hcount_q} >= width_q[act_q] - 4'd1)
      hcount_d = 3'd0;
    else
      hcount_d = hcount_q + 3'd1;

    vcount_d = vcount_q;
    if (vs_fall)
      vcount_d = 2'd0;
    else if (hs_fall) begin
      if ({1'b0, vcount_q} >= height_q[act_q] - 3'd1)
        vcount_d = 2'd0;
      else
        vcount_d = vcount_q + 2'd1;
    end

    mask_d    = en_q[act_q] ? lut_q[act_q][{vcount_q, hcount_q}] : 3'b000;
    mask_en_d = en_q[act_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      act_q     <= 1'b0;
      idx_q     <= 5'd0;
      lut_q     <= '{default: '0};
      width_q   <= '{default: 4'd1};
      height_q  <= '{default: 3'd1};
      en_q      <= '{default: 1'b0};
      hcount_q  <= 3'd0;
      vcount_q  <= 2'd0;
      old_hs_q  <= 1'b0;
      old_vs_q  <= 1'b0;
      mask_q    <= 3'd0;
      mask_en_q <= 1'b0;
      hs_out_q  <= 1'b0;
      vs_out_q  <= 1'b0;
      de_out_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      idx_q     <= idx_d;
      lut_q     <= lut_d;
      width_q   <= width_d;
      height_q  <= height_d;
      en_q      <= en_d;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      old_hs_q  <= bus.hs_in;
      old_vs_q  <= bus.vs_in;
      mask_q    <= mask_d;
      mask_en_q <= mask_en_d;
      hs_out_q  <= bus.hs_in;
      vs_out_q  <= bus.vs_in;
      de_out_q  <= bus.de_in;
    end
  end

  assign bus.cfg_busy = (state_q != IDLE);
  assign bus.mask_rgb = mask_q;
  assign bus.mask_en  = mask_en_q;
  assign bus.hs_out   = hs_out_q;
  assign bus.vs_out   = vs_out_q;
  assign bus.de_out   = de_out_q;
endmodule

// File: tb/tb_shadowmask_ctrl.sv
// Directed bench for shadowmask_ctrl: bank swap, copy, clamping,
// phase counters and reset during copy.
module tb_shadowmask_ctrl;
  logic clk;
  logic reset;
  int checks;
  int failures;

  shadowmask_if bus ();

  shadowmask_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [2:0] seq3 [3] = '{3'd4, 3'd2, 3'd1};
  logic [2:0] pat  [8] = '{3'd5, 3'd3, 3'd6, 3'd1, 3'd7, 3'd2, 3'd0, 3'd4};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    bus.cfg_wr   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    tick();
    bus.cfg_wr   = 1'b0;
  endtask

  task automatic commit;
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.cfg_busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.mask_rgb !== 3'd0) begin
      failures++;
      $display("FAIL reset_mask got=%0d exp=0", bus.mask_rgb);
    end
    checks++;
    if (bus.mask_en !== 1'b0 || bus.cfg_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_en_busy got=%b%b exp=00", bus.mask_en, bus.cfg_busy);
    end
    bus.hs_in = 1'b1;
    bus.de_in = 1'b1;
    tick();
    checks++;
    if ({bus.hs_out, bus.vs_out, bus.de_out} !== 3'b101) begin
      failures++;
      $display("FAIL sync_delay got=%b exp=101",
               {bus.hs_out, bus.vs_out, bus.de_out});
    end
    bus.hs_in = 1'b0;
    bus.de_in = 1'b0;
    tick();
    checks++;
    if ({bus.hs_out, bus.de_out, bus.mask_rgb} !== 5'b00000) begin
      failures++;
      $display("FAIL sync_fall got=%b exp=00000",
               {bus.hs_out, bus.de_out, bus.mask_rgb});
    end
  endtask

  task automatic test_basic_swap;
    int n;
    n = 0;
    wr(6'd0, 8'd4);
    wr(6'd1, 8'd2);
    wr(6'd2, 8'd1);
    wr(6'd32, 8'd3);
    wr(6'd33, 8'd1);
    wr(6'd34, 8'd1);
    checks++;
    if (bus.mask_en !== 1'b0) begin
      failures++;
      $display("FAIL inactive_write got=%b exp=0", bus.mask_en);
    end
    commit();
    checks++;
    if (bus.cfg_busy !== 1'b1) begin
      failures++;
      $display("FAIL commit_busy got=%b exp=1", bus.cfg_busy);
    end
    wr(6'd0, 8'd7);
    bus.vs_in = 1'b1;
    tick();
    bus.vs_in = 1'b0;
    tick();
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k <= 6) begin
        checks++;
        if (bus.mask_rgb !== seq3[(k - 1) % 3]) begin
          failures++;
          $display("FAIL seq3_k%0d got=%0d exp=%0d", k, bus.mask_rgb,
                   seq3[(k - 1) % 3]);
        end
      end
      if (k == 1) begin
        checks++;
        if (bus.mask_en !== 1'b1) begin
          failures++;
          $display("FAIL swap_en got=%b exp=1", bus.mask_en);
        end
      end
      if (bus.cfg_busy === 1'b0 && n == 0) n = k;
    end
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL copy_len got=%0d exp=32", n);
    end
    bus.hs_in = 1'b1;
    tick();
    bus.hs_in = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.mask_rgb !== seq3[k % 3]) begin
        failures++;
        $display("FAIL hs_restart_k%0d got=%0d exp=%0d", k, bus.mask_rgb,
                 seq3[k % 3]);
      end
    end
  endtask

  task automatic test_clamp;
    int n;
    for (int i = 0; i < 8; i++) wr(6'(i), {5'd0, pat[i]});
    wr(6'd32, 8'd12);
    wr(6'd33, 8'd0);
    commit();
    bus.hs_in = 1'b1;
    bus.vs_in = 1'b1;
    tick();
    bus.hs_in = 1'b0;
    bus.vs_in = 1'b0;
    tick();
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (bus.mask_rgb !== pat[(k - 1) % 8]) begin
        failures++;
        $display("FAIL w8_k%0d got=%0d exp=%0d", k, bus.mask_rgb,
                 pat[(k - 1) % 8]);
      end
    end
    bus.hs_in = 1'b1;
    tick();
    bus.hs_in = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.mask_rgb !== pat[k]) begin
        failures++;
        $display("FAIL h1_row_k%0d got=%0d exp=%0d", k, bus.mask_rgb, pat[k]);
      end
    end
    wait_idle(n);
    checks++;
    if (bus.cfg_busy !== 1'b0) begin
      failures++;
      $display("FAIL clamp_idle got=%b exp=0", bus.cfg_busy);
    end
  endtask

  task automatic test_w_shrink;
    int n;
    logic [2:0] exp_s [8];
    exp_s = '{pat[6], pat[7], pat[0], pat[1], pat[2], pat[0], pat[1], pat[2]};
    wr(6'd32, 8'd3);
    commit();
    bus.hs_in = 1'b1;
    bus.vs_in = 1'b1;
    tick();
    bus.hs_in = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) tick();
    bus.vs_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (bus.mask_rgb !== exp_s[k]) begin
        failures++;
        $display("FAIL shrink_k%0d got=%0d exp=%0d", k, bus.mask_rgb, exp_s[k]);
      end
    end
    wait_idle(n);
    checks++;
    if (bus.cfg_busy !== 1'b0) begin
      failures++;
      $display("FAIL shrink_idle got=%b exp=0", bus.cfg_busy);
    end
  endtask

  task automatic test_commit_on_vs_fall;
    int n;
    wr(6'd34, 8'd0);
    bus.vs_in = 1'b1;
    tick();
    bus.vs_in = 1'b0;
    commit();
    checks++;
    if (bus.cfg_busy !== 1'b1) begin
      failures++;
      $display("FAIL armed_busy got=%b exp=1", bus.cfg_busy);
    end
    for (int k = 0; k < 40; k++) tick();
    checks++;
    if ({bus.cfg_busy, bus.mask_en} !== 2'b11) begin
      failures++;
      $display("FAIL armed_wait got=%b exp=11", {bus.cfg_busy, bus.mask_en});
    end
    bus.vs_in = 1'b1;
    tick();
    bus.vs_in = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.mask_en, bus.mask_rgb} !== 4'b0000) begin
      failures++;
      $display("FAIL late_swap got=%b exp=0000", {bus.mask_en, bus.mask_rgb});
    end
    wait_idle(n);
    checks++;
    if (n != 31) begin
      failures++;
      $display("FAIL late_copy_len got=%0d exp=31", n);
    end
  endtask

  task automatic test_reset_in_copy;
    int n;
    wr(6'd34, 8'd1);
    commit();
    bus.vs_in = 1'b1;
    tick();
    bus.vs_in = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if ({bus.cfg_busy, bus.mask_en} !== 2'b11) begin
      failures++;
      $display("FAIL pre_reset got=%b exp=11", {bus.cfg_busy, bus.mask_en});
    end
    reset = 1'b1;
    #2;
    checks++;
    if ({bus.cfg_busy, bus.mask_en, bus.mask_rgb} !== 5'b00000) begin
      failures++;
      $display("FAIL async_reset got=%b exp=00000",
               {bus.cfg_busy, bus.mask_en, bus.mask_rgb});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr(6'd0, 8'd3);
    wr(6'd34, 8'd1);
    commit();
    bus.vs_in = 1'b1;
    tick();
    bus.vs_in = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.mask_en, bus.mask_rgb} !== 4'b1011) begin
      failures++;
      $display("FAIL post_reset_write got=%b exp=1011",
               {bus.mask_en, bus.mask_rgb});
    end
    wait_idle(n);
    checks++;
    if (bus.cfg_busy !== 1'b0) begin
      failures++;
      $display("FAIL final_idle got=%b exp=0", bus.cfg_busy);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    bus.cfg_wr     = 1'b0;
    bus.cfg_addr   = 6'd0;
    bus.cfg_data   = 8'd0;
    bus.cfg_commit = 1'b0;
    bus.hs_in      = 1'b0;
    bus.vs_in      = 1'b0;
    bus.de_in      = 1'b0;
    test_reset();
    test_basic_swap();
    test_clamp();
    test_w_shrink();
    test_commit_on_vs_fall();
    test_reset_in_copy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
